// File: rtl/posit_encoder_if.sv
// Request/result bundle between a posit producer and the posit(32,3) encoder.
interface posit_encoder_if;
    logic               start;
    logic               recieved;
    logic               sign;
    logic               ZERO;
    logic               NAR;
    logic signed [5:0]  k;
    logic [2:0]         exp_value;
    logic [31:0]        mantissa;
    logic [31:0]        posit_num;
    logic               done;

    modport master (
        output start, recieved, sign, ZERO, NAR, k, exp_value, mantissa,
        input  posit_num, done
    );

    modport slave (
        input  start, recieved, sign, ZERO, NAR, k, exp_value, mantissa,
        output posit_num, done
    );
endinterface

// File: rtl/posit_encoder.sv
// Multi-cycle posit(32,3) encoder: builds the regime one bit per cycle, then
// inserts exponent and fraction, and holds the word until acknowledged.
module posit_encoder (
    input  logic            clk,
    input  logic            rst,
    posit_encoder_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, SIGN, REGIME, EXP, FRAC, COMPLETE} state_t;

    state_t             state_reg, state_next;
    logic               sign_reg, sign_next;
    logic               zero_reg, zero_next;
    logic               nar_reg, nar_next;
    logic               k_neg_reg, k_neg_next;
    logic [4:0]         run_reg, run_next;
    logic [4:0]         r_reg, r_next;
    logic [2:0]         exp_reg, exp_next;
    logic [30:0]        frac_reg, frac_next;
    logic [4:0]         cnt_reg, cnt_next;
    logic [30:0]        acc_reg, acc_next;
    logic [31:0]        posit_reg, posit_next;
    logic               done_reg, done_next;

    logic signed [5:0]  k_clamped;
    logic [5:0]         k_abs;
    logic [4:0]         run_in;
    logic [4:0]         r_in;
    logic               regime_bit;
    logic [30:0]        regime_mask;
    logic [30:0]        exp_field;
    logic [30:0]        frac_field;
    logic               unused_hidden;

    // The hidden 1 of the mantissa carries no information in the posit word.
    assign unused_hidden = bus.mantissa[31];

    // Clamp k and derive the identical-bit run length and total regime width r.
    always_comb begin
        k_clamped = bus.k;
        if (bus.k > 6'sd30)
            k_clamped = 6'sd30;
        else if (bus.k < -6'sd30)
            k_clamped = -6'sd30;
        k_abs  = k_clamped[5] ? $unsigned(-k_clamped) : $unsigned(k_clamped);
        run_in = k_clamped[5] ? k_abs[4:0] : k_abs[4:0] + 5'd1;
        r_in   = (!k_clamped[5] && run_in == 5'd31) ? 5'd31 : run_in + 5'd1;
    end

    // Regime bit cnt is written MSB-first, so bit position 30-cnt is selected.
    genvar gi;
    generate
        for (gi = 0; gi < 31; gi++) begin : g_regime_mask
            assign regime_mask[gi] = (cnt_reg == 5'(30 - gi));
        end
    endgenerate

    assign regime_bit = (cnt_reg < run_reg) ^ k_neg_reg;
    assign exp_field  = {exp_reg, 28'd0} >> r_reg;
    assign frac_field = frac_reg >> (6'(r_reg) + 6'd3);

    always_comb begin
        state_next = state_reg;
        sign_next  = sign_reg;
        zero_next  = zero_reg;
        nar_next   = nar_reg;
        k_neg_next = k_neg_reg;
        run_next   = run_reg;
        r_next     = r_reg;
        exp_next   = exp_reg;
        frac_next  = frac_reg;
        cnt_next   = cnt_reg;
        acc_next   = acc_reg;
        posit_next = posit_reg;
        done_next  = done_reg;

        case (state_reg)
            IDLE: begin
                posit_next = 32'd0;
                done_next  = 1'b0;
                if (bus.start) begin
                    sign_next  = bus.sign;
                    zero_next  = bus.ZERO;
                    nar_next   = bus.NAR;
                    k_neg_next = k_clamped[5];
                    run_next   = run_in;
                    r_next     = r_in;
                    exp_next   = bus.exp_value;
                    frac_next  = bus.mantissa[30:0];
                    cnt_next   = 5'd0;
                    acc_next   = 31'd0;
                    state_next = SIGN;
                end
            end
            SIGN: begin
                if (nar_reg) begin
                    posit_next = 32'h8000_0000;
                    state_next = COMPLETE;
                end else if (zero_reg) begin
                    posit_next = 32'h0000_0000;
                    state_next = COMPLETE;
                end else begin
                    state_next = REGIME;
                end
            end
            REGIME: begin
                if (regime_bit)
                    acc_next = acc_reg | regime_mask;
                cnt_next = cnt_reg + 5'd1;
                if (cnt_reg == r_reg - 5'd1)
                    state_next = EXP;
            end
            EXP: begin
                // A 31-bit regime leaves no room for exponent or fraction.
                if (r_reg == 5'd31) begin
                    posit_next = {sign_reg, acc_reg};
                    state_next = COMPLETE;
                end else begin
                    acc_next   = acc_reg | exp_field;
                    state_next = FRAC;
                end
            end
            FRAC: begin
                acc_next   = acc_reg | frac_field;
                posit_next = {sign_reg, acc_reg | frac_field};
                state_next = COMPLETE;
            end
            COMPLETE: begin
                // done must be visible for at least one cycle before release.
                if (done_reg && bus.recieved) begin
                    done_next  = 1'b0;
                    posit_next = 32'd0;
                    state_next = IDLE;
                end else begin
                    done_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            sign_reg  <= 1'b0;
            zero_reg  <= 1'b0;
            nar_reg   <= 1'b0;
            k_neg_reg <= 1'b0;
            run_reg   <= 5'd0;
            r_reg     <= 5'd0;
            exp_reg   <= 3'd0;
            frac_reg  <= 31'd0;
            cnt_reg   <= 5'd0;
            acc_reg   <= 31'd0;
            posit_reg <= 32'd0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            sign_reg  <= sign_next;
            zero_reg  <= zero_next;
            nar_reg   <= nar_next;
            k_neg_reg <= k_neg_next;
            run_reg   <= run_next;
            r_reg     <= r_next;
            exp_reg   <= exp_next;
            frac_reg  <= frac_next;
            cnt_reg   <= cnt_next;
            acc_reg   <= acc_next;
            posit_reg <= posit_next;
            done_reg  <= done_next;
        end
    end

    assign bus.posit_num = posit_reg;
    assign bus.done      = done_reg;
endmodule
